bp_fe_ras_ctrl: RTL
===================

// Module: bp_fe_ras_ctrl
// PURPOSE
//  Front-end pre-decode stage directly upstream of the return-address stack.
//  - Inspects each fetched RV64 instruction and classifies JAL/JALR as call, return or coroutine.
//  - Drives the RAS push/pop strobes and push data.
//  - Hands a registered prediction (kind + target) to pc_gen through a valid/ready output register.
// PARAMETERS
//  eaddr_width_p  64  fetch PC width, bits; zero-extended to 64 on RAS data
//  ras_depth_p    16  RAS entries; saturation bound of depth tracker
//  depth_width_lp $clog2(ras_depth_p)+1  (localparam) depth_o width
// PORTS
//  clk_i          in   1              clock, rising edge
//  reset_n_i      in   1              asynchronous reset, active-low
//  fetch_v_i      in   1              fetch packet valid
//  fetch_ready_o  out  1              stage can accept packet
//  fetch_pc_i     in   eaddr_width_p  PC of fetched instruction
//  fetch_instr_i  in   32             fetched instruction
//  flush_i        in   1              backend redirect; kill stage contents
//  ras_push_o     out  1              push strobe to RAS
//  ras_pop_o      out  1              pop strobe to RAS
//  ras_data_o     out  64             push data = return address
//  ras_data_i     in   64             RAS top-of-stack
//  ras_v_i        in   1              RAS top-of-stack valid
//  pred_v_o       out  1              prediction valid
//  pred_ready_i   in   1              pc_gen accepts prediction
//  pred_pc_o      out  eaddr_width_p  PC of predicted instruction
//  pred_kind_o    out  2              00 none, 01 call, 10 return, 11 coroutine
//  pred_tgt_v_o   out  1              pred_tgt_o usable (return/coroutine only)
//  pred_tgt_o     out  64             predicted return target
//  depth_o        out  depth_width_lp speculative RAS occupancy
// BEHAVIOUR
//  Reset (async assert, sync deassert): state=IDLE; pred_v_o, pred_pc_o, pred_kind_o, pred_tgt_v_o,
//   pred_tgt_o, depth_o all 0.
//  Combinational outputs at reset: ras_push_o=0, ras_pop_o=0, ras_data_o=0, fetch_ready_o=0.
//  Decode: link(r) = (r==x1 || r==x5).
//   JAL (opc 1101111): call iff link(rd); otherwise none.
//   JALR (opc 1100111, f3 000):
//    - !link(rd) & link(rs1) -> return
//    - link(rd) & !link(rs1) -> call
//    - link(rd) & link(rs1) & rd==rs1 -> call
//    - link(rd) & link(rs1) & rd!=rs1 -> coroutine
//   All other encodings -> none.
//  fetch_ready_o = reset_n_i & state==IDLE & !flush_i & (!pred_v_o | pred_ready_i).
//  accept = fetch_v_i & fetch_ready_o. Output register loads on accept; 1-cycle latency.
//  Output register clears when pred_v_o & pred_ready_i & !accept.
//  RAS strobes are combinational in the accept cycle (RAS updates on that edge):
//   - call: ras_push_o=1, ras_data_o = zext(fetch_pc_i+4), sum mod 2^eaddr_width_p.
//   - return: ras_pop_o = (depth_o!=0).
//     Latch pred_tgt_o=ras_data_i, pred_tgt_v_o=ras_v_i & (depth_o!=0).
//   - never push and pop in the same cycle.
//  Back-to-back returns: each sees the post-previous-pop top.
//  FSM: IDLE, PUSH.
//   - IDLE -> PUSH on accepted coroutine (pop in accept cycle, target latched as for return).
//   - PUSH: ras_push_o=1 with saved pc+4; fetch_ready_o=0; -> IDLE next cycle.
//  depth_o: +1 on push, saturating at ras_depth_p (push still issued when saturated).
//   -1 on pop; never below 0.
//  flush_i (synchronous, highest priority):
//   - same cycle: no accept; PUSH push suppressed.
//   - next cycle: pred_v_o=0, state=IDLE.
//   - depth_o not changed by flush itself.
//  Held pred_* outputs stable while pred_v_o & !pred_ready_i.
// CONFIGURATION
//  BP_FE_RAS_CTRL_COROUTINE_EN defined:
//   - coroutine classified as kind 11; pop-then-push via PUSH state (2 cycles, 1 bubble).
//  Undefined:
//   - PUSH state absent; coroutine classified as return (kind 10, pop only, no push).
// TESTING
//  1 Reset low mid-PUSH -> all outputs 0 immediately; no ras_push_o after release.
//  2 Call: JAL x1 at pc 0x8000_0000 -> same cycle ras_push_o=1, ras_data_o=0x8000_0004.
//    Next cycle pred_kind_o=01; depth_o=1.
//  3 Push 0x100 then 0x200; two back-to-back `jalr x0,0(x1)`:
//    - pops in consecutive cycles; pred_tgt_o 0x200 then 0x100, pred_tgt_v_o=1; depth_o 2->1->0.
//  4 Return with depth_o=0 -> ras_pop_o=0, pred_kind_o=10, pred_tgt_v_o=0; depth_o stays 0.
//  5 COROUTINE_EN, depth 1, `jalr x1,0(x5)` at pc 0x40:
//    - cycle0 pop, target latched; cycle1 push 0x44, fetch_ready_o=0; depth_o ends at 1.
//    - Repeat with flush_i in cycle1 -> no push; depth_o=0.
//  6 Stall: pred_ready_i=0 for 5 cycles -> fetch_ready_o=0, pred_* stable.
//    17 calls -> depth_o saturates at 16.

Source files
------------

// File: rtl/bp_fe_ras_ctrl.sv
// ---------------------------------------------------------------------------
// bp_fe_ras_ctrl
//
// Front-end pre-decode stage placed directly in front of the return-address
// stack. Each accepted RV64 instruction is classified as call, return,
// coroutine or none. The stage drives the RAS push/pop strobes in the accept
// cycle, tracks the speculative RAS depth, and hands a registered prediction
// (kind + target) to pc_gen through a valid/ready output register.
//
// Build option:
//   BP_FE_RAS_CTRL_COROUTINE_EN
//     defined   : coroutines are kind 11; pop in the accept cycle, then push
//                 pc+4 from the PUSH state one cycle later (one bubble).
//     undefined : no PUSH state; coroutines are treated as returns (kind 10).
//
// Ports:
//   clk_i          clock, rising edge
//   reset_n_i      asynchronous active-low reset
//   fetch_v_i      fetch packet valid
//   fetch_ready_o  stage can accept a packet this cycle
//   fetch_pc_i     PC of fetched instruction
//   fetch_instr_i  fetched 32-bit instruction
//   flush_i        backend redirect; kills stage contents
//   ras_push_o     push strobe to RAS (combinational)
//   ras_pop_o      pop strobe to RAS (combinational)
//   ras_data_o     push data (return address, zero-extended)
//   ras_data_i     RAS top-of-stack
//   ras_v_i        RAS top-of-stack valid
//   pred_v_o       prediction valid
//   pred_ready_i   pc_gen accepts prediction
//   pred_pc_o      PC of predicted instruction
//   pred_kind_o    00 none, 01 call, 10 return, 11 coroutine
//   pred_tgt_v_o   pred_tgt_o usable
//   pred_tgt_o     predicted return target
//   depth_o        speculative RAS occupancy (saturating)
// ---------------------------------------------------------------------------
module bp_fe_ras_ctrl #(
  parameter  int eaddr_width_p  = 64,
  parameter  int ras_depth_p    = 16,
  localparam int depth_width_lp = $clog2(ras_depth_p) + 1
) (
  input  logic                      clk_i,
  input  logic                      reset_n_i,
  input  logic                      fetch_v_i,
  output logic                      fetch_ready_o,
  input  logic [eaddr_width_p-1:0]  fetch_pc_i,
  input  logic [31:0]               fetch_instr_i,
  input  logic                      flush_i,
  output logic                      ras_push_o,
  output logic                      ras_pop_o,
  output logic [63:0]               ras_data_o,
  input  logic [63:0]               ras_data_i,
  input  logic                      ras_v_i,
  output logic                      pred_v_o,
  input  logic                      pred_ready_i,
  output logic [eaddr_width_p-1:0]  pred_pc_o,
  output logic [1:0]                pred_kind_o,
  output logic                      pred_tgt_v_o,
  output logic [63:0]               pred_tgt_o,
  output logic [depth_width_lp-1:0] depth_o
);

  localparam logic [1:0] kind_none_lp = 2'b00;
  localparam logic [1:0] kind_call_lp = 2'b01;
  localparam logic [1:0] kind_ret_lp  = 2'b10;
`ifdef BP_FE_RAS_CTRL_COROUTINE_EN
  localparam logic [1:0] kind_coro_lp = 2'b11;
`else
  // Without the PUSH state a coroutine degrades to a plain return.
  localparam logic [1:0] kind_coro_lp = 2'b10;
`endif

  localparam logic [depth_width_lp-1:0] depth_max_lp = depth_width_lp'(ras_depth_p);
  localparam logic [depth_width_lp-1:0] depth_one_lp = depth_width_lp'(1'b1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    PUSH = 1'b1
  } state_e;

  // x1 (ra) and x5 (t0) are the RISC-V link registers.
  function automatic logic is_link(input logic [4:0] r);
    is_link = (r == 5'd1) || (r == 5'd5);
  endfunction

  // Classify an instruction into its RAS action.
  function automatic logic [1:0] classify(input logic [31:0] instr);
    logic [6:0] opc;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [2:0] f3;
    logic       rd_link;
    logic       rs1_link;
    opc      = instr[6:0];
    rd       = instr[11:7];
    f3       = instr[14:12];
    rs1      = instr[19:15];
    rd_link  = is_link(rd);
    rs1_link = is_link(rs1);
    classify = kind_none_lp;
    case (opc)
      7'b1101111: begin
        if (rd_link) classify = kind_call_lp;
        else         classify = kind_none_lp;
      end
      7'b1100111: begin
        if (f3 != 3'b000)              classify = kind_none_lp;
        else if (!rd_link && rs1_link) classify = kind_ret_lp;
        else if (rd_link && !rs1_link) classify = kind_call_lp;
        else if (rd_link && rs1_link) begin
          // Same link register on both sides is a call, not a swap.
          if (rd == rs1) classify = kind_call_lp;
          else           classify = kind_coro_lp;
        end
        else classify = kind_none_lp;
      end
      default: classify = kind_none_lp;
    endcase
  endfunction

  state_e                    state_r;
  state_e                    state_n;
  logic [depth_width_lp-1:0] depth_r;
  logic [depth_width_lp-1:0] depth_n;
  logic                      pred_v_r;
  logic [eaddr_width_p-1:0]  pred_pc_r;
  logic [1:0]                pred_kind_r;
  logic                      pred_tgt_v_r;
  logic [63:0]               pred_tgt_r;
`ifdef BP_FE_RAS_CTRL_COROUTINE_EN
  logic [63:0]               push_data_r;
  logic                      is_coro_s;
`endif

  logic                      fetch_ready_s;
  logic                      accept_s;
  logic [1:0]                kind_s;
  logic                      is_call_s;
  logic                      is_ret_s;
  logic                      depth_nz_s;
  logic [eaddr_width_p-1:0]  link_pc_s;
  logic [63:0]               link_data_s;
  logic                      ras_push_s;
  logic                      ras_pop_s;
  logic [63:0]               ras_data_s;
  logic                      unused_instr_s;

  // Upper instruction bits carry immediates only; the RAS decode ignores them.
  assign unused_instr_s = ^fetch_instr_i[31:20];

  // Decode, handshake and return-address arithmetic for the current packet.
  always_comb begin
    kind_s        = classify(fetch_instr_i);
    is_call_s     = (kind_s == kind_call_lp);
    // In the default build kind_coro_lp equals kind_ret_lp, so this also
    // covers coroutines.
    is_ret_s      = (kind_s == kind_ret_lp) || (kind_s == kind_coro_lp);
`ifdef BP_FE_RAS_CTRL_COROUTINE_EN
    is_coro_s     = (kind_s == kind_coro_lp);
`endif
    depth_nz_s    = (depth_r != '0);
    fetch_ready_s = reset_n_i & (state_r == IDLE) & ~flush_i & (~pred_v_r | pred_ready_i);
    accept_s      = fetch_v_i & fetch_ready_s;
    link_pc_s     = fetch_pc_i + eaddr_width_p'(3'd4);
    link_data_s   = 64'(link_pc_s);
  end

  // RAS strobes: push/pop are mutually exclusive by construction.
  always_comb begin
    ras_push_s = 1'b0;
    ras_pop_s  = 1'b0;
    ras_data_s = 64'd0;
`ifdef BP_FE_RAS_CTRL_COROUTINE_EN
    if (state_r == PUSH) begin
      // Second half of a coroutine; a flush in this cycle drops the push.
      if (!flush_i && reset_n_i) begin
        ras_push_s = 1'b1;
        ras_data_s = push_data_r;
      end
      else begin
        ras_push_s = 1'b0;
      end
    end
    else if (accept_s) begin
`else
    if (accept_s) begin
`endif
      if (is_call_s) begin
        ras_push_s = 1'b1;
        ras_data_s = link_data_s;
      end
      else if (is_ret_s) begin
        // Popping an empty speculative stack would corrupt the RAS pointer.
        ras_pop_s = depth_nz_s;
      end
      else begin
        ras_pop_s = 1'b0;
      end
    end
    else begin
      ras_push_s = 1'b0;
    end
  end

  // Next-state and speculative depth update.
  always_comb begin
    state_n = IDLE;
    depth_n = depth_r;
    if (flush_i) begin
      state_n = IDLE;
    end
    else begin
      case (state_r)
        IDLE: begin
`ifdef BP_FE_RAS_CTRL_COROUTINE_EN
          if (accept_s && is_coro_s) state_n = PUSH;
          else                       state_n = IDLE;
`else
          state_n = IDLE;
`endif
        end
        PUSH:    state_n = IDLE;
        default: state_n = IDLE;
      endcase
    end
    // Saturate at the RAS size: the RAS overwrites its oldest entry, so the
    // speculative count must not run past the physical depth.
    if (ras_push_s) begin
      if (depth_r == depth_max_lp) depth_n = depth_r;
      else                         depth_n = depth_r + depth_one_lp;
    end
    else if (ras_pop_s) begin
      depth_n = depth_r - depth_one_lp;
    end
    else begin
      depth_n = depth_r;
    end
  end

  // State, depth and prediction output register.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r      <= IDLE;
      depth_r      <= '0;
      pred_v_r     <= 1'b0;
      pred_pc_r    <= '0;
      pred_kind_r  <= 2'b00;
      pred_tgt_v_r <= 1'b0;
      pred_tgt_r   <= 64'd0;
    end
    else begin
      state_r <= state_n;
      depth_r <= depth_n;
      if (flush_i || (!accept_s && pred_v_r && pred_ready_i)) begin
        pred_v_r     <= 1'b0;
        pred_pc_r    <= '0;
        pred_kind_r  <= 2'b00;
        pred_tgt_v_r <= 1'b0;
        pred_tgt_r   <= 64'd0;
      end
      else if (accept_s) begin
        pred_v_r     <= 1'b1;
        pred_pc_r    <= fetch_pc_i;
        pred_kind_r  <= kind_s;
        pred_tgt_v_r <= is_ret_s & ras_v_i & depth_nz_s;
        pred_tgt_r   <= is_ret_s ? ras_data_i : 64'd0;
      end
      else begin
        pred_v_r     <= pred_v_r;
      end
    end
  end

`ifdef BP_FE_RAS_CTRL_COROUTINE_EN
  // Return address saved for the deferred coroutine push.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      push_data_r <= 64'd0;
    end
    else if (accept_s && is_coro_s && !flush_i) begin
      push_data_r <= link_data_s;
    end
    else begin
      push_data_r <= push_data_r;
    end
  end
`endif

  assign fetch_ready_o = fetch_ready_s;
  assign ras_push_o    = ras_push_s;
  assign ras_pop_o     = ras_pop_s;
  assign ras_data_o    = ras_data_s;
  assign pred_v_o      = pred_v_r;
  assign pred_pc_o     = pred_pc_r;
  assign pred_kind_o   = pred_kind_r;
  assign pred_tgt_v_o  = pred_tgt_v_r;
  assign pred_tgt_o    = pred_tgt_r;
  assign depth_o       = depth_r;

endmodule
